dft16_twiddle_gen: RTL

Sequential twiddle-factor source for the 16-point DFT datapath. It streams W16^(n·k) = cos(2πnk/16) − j·sin(2πnk/16) as signed fixed-point (wr, wi) pairs over a valid/ready handshake. The stream feeds the M-bit coefficient (br, bi) inputs of the complex multiplier. One start pulse produces one frame of 256 words: bin k is the outer loop and sample n is the inner loop, each 0..15. Quarter-wave symmetry keeps the constant table to five entries.

---
 rtl/dft16_twiddle_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dft16_twiddle_gen.sv
// Streams W16^(n*k) twiddle pairs for one 16x16 DFT frame per start pulse.
// Define DFT16_TWID_INVERSE_EN to add the inv port (conjugate output for IDFT).
module dft16_twiddle_gen #(
   parameter int M = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         out_ready,
`ifdef DFT16_TWID_INVERSE_EN
   input  logic         inv,
`endif
   output logic         out_valid,
   output logic [M-1:0] wr,
   output logic [M-1:0] wi,
   output logic [3:0]   k_idx,
   output logic [3:0]   n_idx,
   output logic         last_n,
   output logic         last_frame,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam int SH = M - 11;

   state_t       state_q;
   logic [3:0]   k_q, n_q;
   logic         valid_q, last_n_q, last_f_q, busy_q, done_q;
   logic [M-1:0] wr_q, wi_q;
   logic [3:0]   kidx_q, nidx_q;
`ifdef DFT16_TWID_INVERSE_EN
   logic         inv_q;
`endif

   logic [3:0]   idx;
   logic [2:0]   r, s;
   logic [M-1:0] ca, cb, wr_d, wi_n, wi_d;
   logic         xfer, load;

   function automatic logic [M-1:0] ctab(input logic [2:0] a);
      logic [M-1:0] v;
      unique case (a)
         3'd0:    v = M'(512);
         3'd1:    v = M'(473);
         3'd2:    v = M'(362);
         3'd3:    v = M'(196);
         default: v = '0;
      endcase
      return v << SH;
   endfunction

   // Only (n*k) mod 16 matters, so a 4-bit product is exact.
   assign idx = n_q * k_q;

   always_comb begin
      r    = {1'b0, idx[1:0]};
      s    = 3'd4 - r;
      ca   = ctab(r);
      cb   = ctab(s);
      wr_d = ca;
      wi_n = -cb;
      unique case (idx[3:2])
         2'd0: begin wr_d = ca;  wi_n = -cb; end
         2'd1: begin wr_d = -cb; wi_n = -ca; end
         2'd2: begin wr_d = -ca; wi_n = cb;  end
         2'd3: begin wr_d = cb;  wi_n = ca;  end
      endcase
`ifdef DFT16_TWID_INVERSE_EN
      wi_d = inv_q ? -wi_n : wi_n;
`else
      wi_d = wi_n;
`endif
   end

   assign xfer = valid_q && out_ready;
   assign load = (state_q == RUN) && !(valid_q && last_f_q)
              && (!valid_q || out_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         n_q      <= '0;
         valid_q  <= 1'b0;
         wr_q     <= '0;
         wi_q     <= '0;
         kidx_q   <= '0;
         nidx_q   <= '0;
         last_n_q <= 1'b0;
         last_f_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef DFT16_TWID_INVERSE_EN
         inv_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
`ifdef DFT16_TWID_INVERSE_EN
                  inv_q   <= inv;
`endif
               end
            end
            RUN: begin
               if (xfer && last_f_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
         endcase
         if (load) begin
            valid_q  <= 1'b1;
            wr_q     <= wr_d;
            wi_q     <= wi_d;
            kidx_q   <= k_q;
            nidx_q   <= n_q;
            last_n_q <= (n_q == 4'd15);
            last_f_q <= (n_q == 4'd15) && (k_q == 4'd15);
            n_q      <= n_q + 4'd1;
            if (n_q == 4'd15) k_q <= k_q + 4'd1;
         end else if (xfer) begin
            valid_q  <= 1'b0;
         end
      end
   end

   assign out_valid  = valid_q;
   assign wr         = wr_q;
   assign wi         = wi_q;
   assign k_idx      = kidx_q;
   assign n_idx      = nidx_q;
   assign last_n     = last_n_q;
   assign last_frame = last_f_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
